bmc_subframe_decoder: RTL and testbench
=======================================

Name: bmc_subframe_decoder

Overview:
Receive-side counterpart of the transmit frame assembly stage. It sits on the optical receiver FPGA directly after the photodiode comparator input.
- Oversamples the biphase-mark (BMC) line and measures the run length between transitions.
- Detects the B/M/W preambles and decodes the 28 data slots of each 32-slot subframe.
- Presents the 20-bit audio sample plus aux/V/U/C bits, with parity check and sync status, to the downstream sample FIFO.

Parameters:
- HALF_UI, 8, clock cycles per BMC half-bit cell; must be >= 4.

Ports:
- clk  input  1  system clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- din  input  1  raw asynchronous BMC line from the optical receiver
- audio_out  output  20  decoded audio sample, slots 8..27, LSB first on the line
- aux_out  output  4  slots 4..7, aux_out[0] = slot 4
- v_out, u_out, c_out  output  1 each  slots 28, 29, 30
- preamble  output  2  type of the subframe just decoded: 0 = B, 1 = M, 2 = W
- valid  output  1  one-cycle strobe; all data outputs are valid and held until the next strobe
- parity_err  output  1  qualified by valid; slots 4..31 have odd parity
- sync_err  output  1  one-cycle pulse on a loss of sync
- locked  output  1  high while subframes are decoding cleanly

Behaviour:
- Reset: every output is 0; the FSM enters HUNT; the run counter is cleared.
- Reset mid-subframe discards the partial subframe. No valid is issued until a full preamble is seen.
- Front end:
  - 2-FF synchronizer, then an edge detector that pulses on every transition.
  - Run length c = clock cycles between consecutive edge pulses.
- Run classification (integer math, H = HALF_UI):
  - SHORT: H/2 <= c < 3H/2
  - LONG: 3H/2 <= c < 5H/2
  - TRIPLE: 5H/2 <= c < 7H/2
  - BAD: anything else
  - For H = 8: SHORT 4..11, LONG 12..19, TRIPLE 20..27.
- Timeout: when the counter reaches 7H/2 without an edge, a BAD run is declared immediately. The counter saturates.
- FSM states:
  - HUNT: ignore all runs except TRIPLE; TRIPLE -> PRE.
  - PRE: collect the next 3 runs. Patterns:
    - (1,1,3) -> B
    - (3,1,1) -> M
    - (2,1,2) -> W
    - Any other pattern -> HUNT, with sync_err pulsed only if locked.
    - Valid pattern -> DATA, slot index = 4.
  - DATA:
    - LONG = bit 0.
    - SHORT, SHORT = bit 1.
    - SHORT followed by a non-SHORT, a TRIPLE, or a BAD run -> sync_err, HUNT, locked <= 0.
    - Each decoded bit shifts into its slot register.
    - The bit completing slot 31 -> WAIT_PRE.
  - WAIT_PRE: the closing edge of slot 31 is the opening edge of the next preamble.
    - The next run must be TRIPLE: it is consumed as the first preamble run, and the FSM goes to PRE.
    - Otherwise: sync_err, HUNT.
- Output timing:
  - valid asserts the cycle after the edge pulse that completes slot 31.
  - The data outputs, preamble and parity_err update in that same cycle.
- Latency: line edge to edge pulse is 3 cycles (2 synchronizer + 1 detect).
- locked:
  - Set with the first valid strobe.
  - Cleared by sync_err or rst.
  - Parity errors do not clear it.
- Simultaneous events: a timeout and an edge in the same cycle count as the edge (the run is classified, not timed out).

Optional Feature:
- GLITCH_FILTER_EN defined: a 3-tap majority filter sits after the synchronizer.
  - Single-cycle spikes are removed.
  - Edge latency rises to 5 cycles.
  - Run classification is unchanged.
- Undefined: no filter; a 1-cycle spike yields a BAD run.

Decomposition:
- Package spdif_pkg:
  - preamble_t enum {PRE_B = 0, PRE_M = 1, PRE_W = 2}.
  - run_t enum {RUN_SHORT, RUN_LONG, RUN_TRIPLE, RUN_BAD}.
  - Slot constants: AUX_LO = 4, AUDIO_LO = 8, AUDIO_W = 20, SLOT_V = 28, SLOT_U = 29, SLOT_C = 30, SLOT_P = 31.
  - The transmit frame assembly stage shares this package.
- Sub-module bmc_run_classifier:
  - Contains the synchronizer, optional filter, edge detect, run counter, thresholds and timeout.
  - Outputs a run_valid strobe plus a run_t value.
- The top level holds the FSM, the shift registers and parity.

Test Plan (HALF_UI = 8):
- B preamble, audio 20'hA5A5A, aux 4'h0, V=0, U=0, C=1, correct parity -> single valid, audio_out = 20'hA5A5A, preamble = 0, c_out = 1, parity_err = 0, locked = 1.
- Back-to-back M, W, B subframes -> preamble = 1, 2, 0 in order; valid strobes spaced exactly 512 cycles apart.
- Same subframe with the P bit inverted -> valid with parity_err = 1, audio still 20'hA5A5A, locked stays 1.
- 6-cycle run inserted in audio slot 12 -> sync_err pulse, no valid, locked = 0; the next clean W subframe decodes and locked returns to 1.
- Line held constant for 40 cycles mid-DATA -> sync_err 28 cycles after the last edge; then rst mid-preamble -> all outputs 0, and the next full subframe decodes correctly.
- 1-cycle spike in slot 10: with GLITCH_FILTER_EN -> clean decode; without -> sync_err.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared S/PDIF subframe definitions: preamble and run types, slot positions.
// Used by both the transmit frame assembly stage and the BMC receive decoder.
package spdif_pkg;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [1:0] {
        RUN_SHORT,
        RUN_LONG,
        RUN_TRIPLE,
        RUN_BAD
    } run_t;

    localparam int unsigned AUX_LO   = 4;
    localparam int unsigned AUDIO_LO = 8;
    localparam int unsigned AUDIO_W  = 20;
    localparam int unsigned SLOT_V   = 28;
    localparam int unsigned SLOT_U   = 29;
    localparam int unsigned SLOT_C   = 30;
    localparam int unsigned SLOT_P   = 31;

    // Slots 4..31 carry one decoded bit each.
    localparam int unsigned DATA_SLOTS = SLOT_P - AUX_LO + 1;

endpackage

// File: rtl/bmc_run_classifier.sv
// BMC front end: synchronizer, optional majority filter (GLITCH_FILTER_EN), edge detect,
// run-length counter with timeout, and SHORT/LONG/TRIPLE/BAD classification.
module bmc_run_classifier
    import spdif_pkg::*;
#(
    parameter int unsigned HALF_UI = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic run_valid,
    output run_t run
);

    localparam int unsigned TMO = (7 * HALF_UI) / 2;
    localparam int unsigned CW  = $clog2(TMO + 2);

    localparam logic [CW-1:0] LIM_SHORT  = CW'(HALF_UI / 2);
    localparam logic [CW-1:0] LIM_LONG   = CW'((3 * HALF_UI) / 2);
    localparam logic [CW-1:0] LIM_TRIPLE = CW'((5 * HALF_UI) / 2);
    localparam logic [CW-1:0] LIM_BAD    = CW'(TMO);
    localparam logic [CW-1:0] CNT_SAT    = CW'(TMO + 1);

    logic          sync1_q, sync2_q;
    logic          line;
    logic          line_prev_q;
    logic          edge_q;
    logic [CW-1:0] cnt_q;
    logic          timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

`ifdef GLITCH_FILTER_EN
    logic [1:0] tap_q;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q  <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            tap_q  <= {tap_q[0], sync2_q};
            filt_q <= (sync2_q & tap_q[0]) | (sync2_q & tap_q[1]) | (tap_q[0] & tap_q[1]);
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    // cnt_q holds the number of cycles since the last edge pulse; it parks one above the
    // timeout value so the timeout strobe fires exactly once per silent stretch.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_prev_q <= 1'b0;
            edge_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            line_prev_q <= line;
            edge_q      <= line ^ line_prev_q;
            if (edge_q) begin
                cnt_q <= CW'(1);
            end else if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign timeout   = !edge_q && (cnt_q == LIM_BAD);
    assign run_valid = edge_q || timeout;

    always_comb begin
        run = RUN_BAD;
        if (edge_q) begin
            if (cnt_q >= LIM_SHORT && cnt_q < LIM_LONG) begin
                run = RUN_SHORT;
            end else if (cnt_q >= LIM_LONG && cnt_q < LIM_TRIPLE) begin
                run = RUN_LONG;
            end else if (cnt_q >= LIM_TRIPLE && cnt_q < LIM_BAD) begin
                run = RUN_TRIPLE;
            end
        end
    end

endmodule

// File: rtl/bmc_subframe_decoder.sv
// BMC subframe decoder: preamble detection, slot shift register, parity and sync tracking.
// Build option: define GLITCH_FILTER_EN to add a 3-tap majority filter to the front end.
module bmc_subframe_decoder
    import spdif_pkg::*;
#(
    parameter int unsigned HALF_UI = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [19:0] audio_out,
    output logic [3:0]  aux_out,
    output logic        v_out,
    output logic        u_out,
    output logic        c_out,
    output logic [1:0]  preamble,
    output logic        valid,
    output logic        parity_err,
    output logic        sync_err,
    output logic        locked
);

    typedef enum logic [1:0] {StHunt, StPre, StData, StWaitPre} state_t;

    logic run_valid;
    run_t run;

    bmc_run_classifier #(
        .HALF_UI(HALF_UI)
    ) u_classifier (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .run_valid (run_valid),
        .run       (run)
    );

    state_t                state_q, state_d;
    logic [1:0]            pre_cnt_q, pre_cnt_d;
    run_t                  r0_q, r0_d, r1_q, r1_d;
    preamble_t             pre_type_q, pre_type_d;
    logic                  half_q, half_d;
    logic [4:0]            slot_q, slot_d;
    logic [DATA_SLOTS-1:0] sh_q, sh_d, shifted;

    logic [19:0]           audio_q, audio_d;
    logic [3:0]            aux_q, aux_d;
    logic                  v_q, v_d, u_q, u_d, c_q, c_d;
    preamble_t             pre_out_q, pre_out_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  locked_q, locked_d;

    logic                  bit_en, bit_val, frame_err;
    logic                  pre_match;
    preamble_t             pre_found;

    // Third preamble run has arrived: match the collected triple against B/M/W.
    always_comb begin
        pre_match = 1'b1;
        pre_found = PRE_B;
        if (r0_q == RUN_SHORT && r1_q == RUN_SHORT && run == RUN_TRIPLE) begin
            pre_found = PRE_B;
        end else if (r0_q == RUN_TRIPLE && r1_q == RUN_SHORT && run == RUN_SHORT) begin
            pre_found = PRE_M;
        end else if (r0_q == RUN_LONG && r1_q == RUN_SHORT && run == RUN_LONG) begin
            pre_found = PRE_W;
        end else begin
            pre_match = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        pre_type_d = pre_type_q;
        half_d     = half_q;
        slot_d     = slot_q;
        sh_d       = sh_q;
        audio_d    = audio_q;
        aux_d      = aux_q;
        v_d        = v_q;
        u_d        = u_q;
        c_d        = c_q;
        pre_out_d  = pre_out_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        serr_d     = 1'b0;
        locked_d   = locked_q;
        bit_en     = 1'b0;
        bit_val    = 1'b0;
        frame_err  = 1'b0;
        shifted    = sh_q;

        unique case (state_q)
            StHunt: begin
                if (run_valid && run == RUN_TRIPLE) begin
                    state_d   = StPre;
                    pre_cnt_d = 2'd0;
                end
            end
            StPre: begin
                if (run_valid) begin
                    if (run == RUN_BAD) begin
                        state_d = StHunt;
                        serr_d  = locked_q;
                    end else if (pre_cnt_q == 2'd0) begin
                        r0_d      = run;
                        pre_cnt_d = 2'd1;
                    end else if (pre_cnt_q == 2'd1) begin
                        r1_d      = run;
                        pre_cnt_d = 2'd2;
                    end else if (pre_match) begin
                        state_d    = StData;
                        pre_type_d = pre_found;
                        slot_d     = 5'(AUX_LO);
                        half_d     = 1'b0;
                    end else begin
                        state_d = StHunt;
                        serr_d  = locked_q;
                    end
                end
            end
            StData: begin
                if (run_valid) begin
                    case (run)
                        RUN_LONG: begin
                            if (half_q) frame_err = 1'b1;
                            else        bit_en    = 1'b1;
                        end
                        RUN_SHORT: begin
                            if (half_q) begin
                                bit_en  = 1'b1;
                                bit_val = 1'b1;
                                half_d  = 1'b0;
                            end else begin
                                half_d  = 1'b1;
                            end
                        end
                        default: frame_err = 1'b1;
                    endcase
                end
            end
            StWaitPre: begin
                // The edge closing slot 31 opened the next preamble; its first run is here.
                if (run_valid) begin
                    if (run == RUN_TRIPLE) begin
                        state_d   = StPre;
                        pre_cnt_d = 2'd0;
                    end else begin
                        state_d = StHunt;
                        serr_d  = 1'b1;
                    end
                end
            end
        endcase

        if (frame_err) begin
            state_d = StHunt;
            serr_d  = 1'b1;
        end

        if (bit_en) begin
            shifted = {bit_val, sh_q[DATA_SLOTS-1:1]};
            sh_d    = shifted;
            if (slot_q == 5'(SLOT_P)) begin
                state_d   = StWaitPre;
                valid_d   = 1'b1;
                locked_d  = 1'b1;
                aux_d     = shifted[0 +: 4];
                audio_d   = shifted[AUDIO_LO - AUX_LO +: AUDIO_W];
                v_d       = shifted[SLOT_V - AUX_LO];
                u_d       = shifted[SLOT_U - AUX_LO];
                c_d       = shifted[SLOT_C - AUX_LO];
                pre_out_d = pre_type_q;
                perr_d    = ^shifted;
            end else begin
                slot_d = slot_q + 5'd1;
            end
        end

        if (serr_d) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHunt;
            pre_cnt_q  <= 2'd0;
            r0_q       <= RUN_SHORT;
            r1_q       <= RUN_SHORT;
            pre_type_q <= PRE_B;
            half_q     <= 1'b0;
            slot_q     <= 5'd0;
            sh_q       <= '0;
            audio_q    <= '0;
            aux_q      <= '0;
            v_q        <= 1'b0;
            u_q        <= 1'b0;
            c_q        <= 1'b0;
            pre_out_q  <= PRE_B;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            pre_type_q <= pre_type_d;
            half_q     <= half_d;
            slot_q     <= slot_d;
            sh_q       <= sh_d;
            audio_q    <= audio_d;
            aux_q      <= aux_d;
            v_q        <= v_d;
            u_q        <= u_d;
            c_q        <= c_d;
            pre_out_q  <= pre_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            locked_q   <= locked_d;
        end
    end

    assign audio_out  = audio_q;
    assign aux_out    = aux_q;
    assign v_out      = v_q;
    assign u_out      = u_q;
    assign c_out      = c_q;
    assign preamble   = pre_out_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign sync_err   = serr_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_bmc_subframe_decoder.sv
// Self-checking bench for bmc_subframe_decoder (HALF_UI = 8): table-driven subframes
// checked through a scoreboard, plus corrupted-run, spike, timeout and reset sequences.
module tb_bmc_subframe_decoder;

`ifdef GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [19:0] audio_out;
    logic [3:0]  aux_out;
    logic        v_out, u_out, c_out;
    logic [1:0]  preamble;
    logic        valid, parity_err, sync_err, locked;

    bmc_subframe_decoder #(
        .HALF_UI(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .audio_out  (audio_out),
        .aux_out    (aux_out),
        .v_out      (v_out),
        .u_out      (u_out),
        .c_out      (c_out),
        .preamble   (preamble),
        .valid      (valid),
        .parity_err (parity_err),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pre;
        logic [19:0] audio;
        logic [3:0]  aux;
        logic        v;
        logic        u;
        logic        c;
        logic        flip;
        logic        perr;
        int          gap;
    } vec_t;

    vec_t sb[$];
    int   runs[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   last_tog_cyc = 0;
    int   serr_cnt = 0;
    int   serr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_audio"}, 32'(audio_out), 32'd0);
        check({tag, "_aux"}, 32'(aux_out), 32'd0);
        check({tag, "_vuc"}, 32'({v_out, u_out, c_out}), 32'd0);
        check({tag, "_preamble"}, 32'(preamble), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    function automatic logic [27:0] make_slots(input vec_t v);
        logic [27:0] s;
        s        = '0;
        s[3:0]   = v.aux;
        s[23:4]  = v.audio;
        s[24]    = v.v;
        s[25]    = v.u;
        s[26]    = v.c;
        s[27]    = (^s[26:0]) ^ v.flip;
        return s;
    endfunction

    // Run lengths in cycles; each run starts with a line transition.
    task automatic add_frame(input vec_t v, input int nslots, input int ins_slot,
                             input int spike_slot);
        logic [27:0] s;
        s = make_slots(v);
        runs.push_back(24);
        case (v.pre)
            2'd0:    begin runs.push_back(8);  runs.push_back(8); runs.push_back(24); end
            2'd1:    begin runs.push_back(24); runs.push_back(8); runs.push_back(8);  end
            default: begin runs.push_back(16); runs.push_back(8); runs.push_back(16); end
        endcase
        for (int k = 0; k < nslots; k++) begin
            if (k + 4 == ins_slot) runs.push_back(6);
            if (s[k]) begin
                runs.push_back(8);
                runs.push_back(8);
            end else if (k + 4 == spike_slot) begin
                runs.push_back(7);
                runs.push_back(1);
                runs.push_back(8);
            end else begin
                runs.push_back(16);
            end
        end
    endtask

    task automatic play();
        while (runs.size() > 0) begin
            int r;
            r = runs.pop_front();
            din = ~din;
            last_tog_cyc = cyc;
            repeat (r) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Closing edge of slot 31, then silence long enough for the WAIT_PRE timeout.
    task automatic tail();
        din = ~din;
        last_tog_cyc = cyc;
        idle(50);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard monitor: pops one expected record per valid strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_valid: valid=1 preamble=%0d audio=%0h, none expected",
                                 preamble, audio_out);
                    end else begin
                        vec_t e;
                        e = sb.pop_front();
                        check("audio_out", 32'(audio_out), 32'(e.audio));
                        check("aux_out", 32'(aux_out), 32'(e.aux));
                        check("v_out", 32'(v_out), 32'(e.v));
                        check("u_out", 32'(u_out), 32'(e.u));
                        check("c_out", 32'(c_out), 32'(e.c));
                        check("preamble", 32'(preamble), 32'(e.pre));
                        check("parity_err", 32'(parity_err), 32'(e.perr));
                        check("locked_at_valid", 32'(locked), 32'd1);
                        if (e.gap != 0) check("valid_gap", 32'(cyc - last_valid_cyc), 32'(e.gap));
                    end
                    last_valid_cyc = cyc;
                end
                if (sync_err) begin
                    serr_cnt++;
                    serr_cyc = cyc;
                end
            end
        end
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   base;

        tbl[0] = '{2'd0, 20'hA5A5A, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd1, 20'h12345, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 512};
        tbl[2] = '{2'd2, 20'hFFFFF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 512};
        tbl[3] = '{2'd0, 20'h00000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 512};
        tbl[4] = '{2'd1, 20'hA5A5A, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 512};
        tbl[5] = '{2'd2, 20'h5A5A5, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 512};

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle(40);

        // Back-to-back table subframes, then a closing edge and silence
        base = serr_cnt;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(tbl[i]);
            add_frame(tbl[i], 28, -1, -1);
            play();
        end
        tail();
        check("table_drained", 32'(sb.size()), 32'd0);
        check("table_sync_err_count", 32'(serr_cnt - base), 32'd1);
        check("locked_after_tail", 32'(locked), 32'd0);

        // Extra 6-cycle run at slot 12 breaks the middle subframe
        idle(40);
        base = serr_cnt;
        v = tbl[0];
        sb.push_back(v);
        add_frame(v, 28, -1, -1);
        play();
        v = '{2'd1, 20'hA5A5A, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        add_frame(v, 28, 12, -1);
        play();
        check("glitch6_sync_err_count", 32'(serr_cnt - base), 32'd1);
        check("glitch6_locked", 32'(locked), 32'd0);
        v = '{2'd2, 20'hA5A5A, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        sb.push_back(v);
        add_frame(v, 28, -1, -1);
        play();
        tail();
        check("glitch6_drained", 32'(sb.size()), 32'd0);
        check("glitch6_total_sync_err", 32'(serr_cnt - base), 32'd2);

        // 1-cycle spike in slot 10
        idle(40);
        base = serr_cnt;
        v = tbl[0];
`ifdef GLITCH_FILTER_EN
        sb.push_back(v);
`endif
        add_frame(v, 28, -1, 10);
        play();
        tail();
        check("spike_drained", 32'(sb.size()), 32'd0);
        check("spike_sync_err_count", 32'(serr_cnt - base), 32'd1);

        // Line frozen mid-DATA: timeout 28 cycles after the last edge pulse
        idle(40);
        base = serr_cnt;
        add_frame(tbl[0], 6, -1, -1);
        play();
        idle(40);
        check("timeout_sync_err_count", 32'(serr_cnt - base), 32'd1);
        check("timeout_cycle", 32'(serr_cyc - last_tog_cyc), 32'(LAT + 29));
        check("timeout_locked", 32'(locked), 32'd0);

        // Reset in the middle of a preamble, then a clean subframe
        idle(40);
        base = serr_cnt;
        runs.push_back(24);
        runs.push_back(8);
        play();
        din = ~din;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_pre_reset");
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        v = '{2'd0, 20'h3C3C3, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        sb.push_back(v);
        add_frame(v, 28, -1, -1);
        play();
        tail();
        check("post_reset_drained", 32'(sb.size()), 32'd0);
        check("post_reset_sync_err_count", 32'(serr_cnt - base), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
